seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential unsigned restoring divider; the inverse operation to the team's combinational multiplier.
- Computes quotient and remainder of dividend / divisor, one quotient bit per clock.
- Uses a start/done handshake and sits beside the multiplier in the arithmetic datapath.

Parameters:
- WIDTH, 4, bit width of dividend, divisor, quotient and remainder (must be >= 2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when the block is idle.
- dividend  input  WIDTH  unsigned dividend; sampled on the accepted start edge.
- divisor  input  WIDTH  unsigned divisor; sampled on the accepted start edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_by_zero  output  1  high with done when the sampled divisor was 0.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE, iteration counter=0.
- State machine has two states, IDLE and CALC.
- IDLE, start=1, divisor!=0, sampled at edge k:
  - Load the shift register with the dividend and clear the partial remainder (WIDTH+1 bits).
  - Clear the counter; busy=1; done=0; div_by_zero=0; go to CALC.
- CALC, edges k+1 .. k+WIDTH, one restoring step per edge:
  - r' = {r, msb of shift reg}.
  - If r' >= divisor: r = r' - divisor and shift in 1; else r = r' and shift in 0.
  - Counter increments each step.
- Final step, edge k+WIDTH:
  - Register quotient/remainder; done=1 for exactly one cycle; busy=0; return to IDLE.
  - Latency is WIDTH cycles from the start edge to done.
- Divide by zero (IDLE, start=1, divisor=0 at edge k):
  - No CALC. At edge k: done=1, div_by_zero=1, quotient=all ones, remainder=dividend.
  - busy stays 0. Latency is 1 cycle.
- Results hold until the next accepted start. div_by_zero holds with them.
- start while busy is ignored. Inputs are not re-sampled and the result is unaffected.
- start in the cycle done is high is accepted (back-to-back operation):
  - At that edge done drops and busy rises.
  - quotient/remainder keep the previous values until the new done.
- rst high at any edge, including mid-CALC:
  - Abort, return to reset values; no done is produced.
  - rst dominates start when both are high.
- Remainder is always < divisor. quotient*divisor + remainder == dividend, computed in 2*WIDTH bits.
- Partial-remainder compare/subtract is done in WIDTH+1 bits so no carry is lost when divisor has its msb set.

Decomposition:
- Package div_pkg holds:
  - state enum (IDLE, CALC);
  - counter width function clog2(WIDTH+1).
- One natural sub-module, div_step: combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once in CALC.

Test Plan:
- WIDTH=4, dividend=13, divisor=3, start at edge k -> busy high on edges k+1..k+3; at edge k+4 done=1, quotient=4, remainder=1, div_by_zero=0.
- Boundary values:
  - 15/15 -> q=1, r=0.
  - 15/1 -> q=15, r=0.
  - 0/5 -> q=0, r=0.
  - 2/9 -> q=0, r=2.
- Divide by zero, 7/0 -> done at edge k, q=15, r=7, div_by_zero=1, busy never high.
- Handshake:
  - 13/3, then start with 9/2 pulsed mid-CALC -> first result still q=4, r=1.
  - start 9/2 held high on the done cycle -> q=4, r=1 after 4 more cycles.
- Reset: rst asserted two cycles into 13/3 -> next edge shows all outputs 0 and IDLE; no done appears; a following 6/4 gives q=1, r=2.
- Exhaustive WIDTH=4 over all 256 operand pairs vs a behavioural model -> quotient, remainder and div_by_zero match, and latency is 4 cycles (1 when divisor=0).

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    // Divider control states: waiting for a request, or stepping through quotient bits.
    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Ceiling log2, used to size the iteration counter as clog2(WIDTH+1).
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);
    localparam int RW = WIDTH + 1;

    // Work one bit wider than the stored remainder so the shift never drops a bit
    // and the compare stays correct when the divisor has its msb set.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dvs_ext;

    // Trial subtract; keep the difference only when it does not go negative.
    always_comb begin
        shifted = {rem_i, bit_i};
        dvs_ext = {2'b00, divisor_i};
        qbit_o  = (shifted >= dvs_ext);
        rem_o   = qbit_o ? RW'(shifted - dvs_ext) : RW'(shifted);
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Latency: WIDTH cycles from the accepted start edge to done; divide-by-zero reports on the start edge.
// Backpressure: start is ignored while busy; results hold until the next accepted start.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Holds the remaining dividend bits at the top and collects quotient bits at the bottom.
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_rem;
    logic             step_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (shift_q[WIDTH-1]),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state logic: accept requests in IDLE, run one restoring step per cycle in CALC.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // No iterations needed: report immediately with saturated quotient.
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                        quot_d = '1;
                        remd_d = dividend;
                    end else begin
                        shift_d = dividend;
                        rem_d   = '0;
                        dvsr_d  = divisor;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                shift_d = {shift_q[WIDTH-2:0], step_qbit};
                rem_d   = step_rem;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    quot_d  = {shift_q[WIDTH-2:0], step_qbit};
                    remd_d  = step_rem[WIDTH-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=4: stimulus queues expectations, a monitor checks each done.
// Latency: checks the done edge against the start edge (4 edges, or the same edge for divide-by-zero).
// Backpressure: exercises start while busy, start on the done cycle, and reset mid-division.
module tb_seq_divider;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           done_edge;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_cmp;
    int   n_err;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so expectations can name the edge where done must appear.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, cyc);
        end
    endtask

    // Drive one request at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (push) begin
            e.q         = (b == 0) ? 4'hF : 4'(a / b);
            e.r         = (b == 0) ? a : 4'(a % b);
            e.dbz       = (b == 0);
            e.done_edge = cyc + 1 + ((b == 0) ? 0 : W);
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected none (edge %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.dbz);
                    chk("done_edge", cyc, e.done_edge);
                    chk("busy_at_done", busy, 0);
                end
            end
        end
    end

    logic [W-1:0] bnd_a[4] = '{4'd15, 4'd15, 4'd0, 4'd2};
    logic [W-1:0] bnd_b[4] = '{4'd15, 4'd1, 4'd5, 4'd9};

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        // 13/3: busy through the calculation, done four edges after start.
        issue(4'd13, 4'd3, 1'b1);
        chk("busy_calc", busy, 1);
        repeat (3) begin
            @(negedge clk);
            chk("busy_calc", busy, 1);
        end
        repeat (3) @(negedge clk);

        // 7/0: reported on the start edge without ever going busy.
        issue(4'd7, 4'd0, 1'b1);
        chk("dbz_busy", busy, 0);
        @(negedge clk);
        chk("dbz_busy_after", busy, 0);
        chk("dbz_done_pulse", done, 0);
        repeat (2) @(negedge clk);

        // Boundary operand pairs.
        for (int i = 0; i < 4; i++) begin
            issue(bnd_a[i], bnd_b[i], 1'b1);
            repeat (5) @(negedge clk);
        end

        // A second start mid-calculation is ignored.
        issue(4'd13, 4'd3, 1'b1);
        issue(4'd9, 4'd2, 1'b0);
        repeat (5) @(negedge clk);

        // Start on the done cycle is accepted back-to-back.
        issue(4'd13, 4'd3, 1'b1);
        repeat (4) @(negedge clk);
        chk("b2b_done_seen", done, 1);
        issue(4'd9, 4'd2, 1'b1);
        chk("b2b_done_drop", done, 0);
        chk("b2b_busy_rise", busy, 1);
        chk("b2b_hold_q", quotient, 4);
        chk("b2b_hold_r", remainder, 1);
        repeat (6) @(negedge clk);

        // Reset two cycles into a division aborts it with no done.
        issue(4'd13, 4'd3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(4'd6, 4'd4, 1'b1);
        repeat (6) @(negedge clk);

        // All operand pairs against the behavioural model.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(4'(a), 4'(b), 1'b1);
                repeat (5) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        #1;
        chk("pending_results", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
